// File: rtl/barcode_pkg.sv
// Shared timing constants and state encoding for the barcode link.
// Imported by the transmitter, the receiver and their benches.
package barcode_pkg;

    localparam int BC_PERIOD_DEF = 512;

    // Low time of each cell type, in quarter cell periods
    localparam int Q_START = 2;
    localparam int Q_ONE   = 1;
    localparam int Q_ZERO  = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        TRAIL
    } bc_state_t;

    function automatic int low_quarters(
        input logic is_start,
        input logic bit_v
    );
        if (is_start) begin
            return Q_START;
        end
        return bit_v ? Q_ONE : Q_ZERO;
    endfunction

endpackage

// File: rtl/barcode_tx.sv
// Barcode station-ID transmitter: start cell, 8 data cells MSB first,
// then a one-cell high trailer, as a pulse-width coded frame on BC.
module barcode_tx
    import barcode_pkg::*;
#(
    parameter int PERIOD = BC_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] station_id,
    output logic       BC,
    output logic       busy,
    output logic       done
);

    localparam int CW  = $clog2(PERIOD);
    localparam int QTR = PERIOD / 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    bc_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    sr_q, sr_d;
    logic          bc_q, bc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [CW-1:0] low_last;
    logic          cell_end;

    // Next state, counters and registered outputs derived from next state
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        sr_d     = sr_q;
        done_d   = 1'b0;
        low_last = CW'(low_quarters(idx_q == 4'd0, sr_q[7]) * QTR - 1);
        cell_end = (cnt_q == CNT_LAST);

        unique case (state_q)
            IDLE: begin
                if (send) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    sr_d    = station_id;
                end
            end
            LOW: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == low_last) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cell_end) begin
                    cnt_d = '0;
                    if (idx_q == 4'd8) begin
                        state_d = TRAIL;
                    end else begin
                        state_d = LOW;
                        idx_d   = idx_q + 4'd1;
                        // The start cell carries no data bit, so no shift
                        if (idx_q != 4'd0) begin
                            sr_d = {sr_q[6:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TRAIL: begin
                if (cell_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        bc_d   = (state_d != LOW);
        busy_d = (state_d != IDLE);
    end

    // State, counters and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 4'd0;
            sr_q    <= 8'h00;
            bc_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            bc_q    <= bc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign BC   = bc_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_barcode_tx.sv
// Self-checking bench for barcode_tx with PERIOD=16: per-cycle waveform
// scoreboard, pulse-width receiver model and frame-level checks.
module tb_barcode_tx;
    import barcode_pkg::*;

    localparam int P = 16;
    localparam int FRAME = 10 * P;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] station_id = 8'h00;
    logic       bc_o;
    logic       busy_o;
    logic       done_o;

    barcode_tx #(.PERIOD(P)) dut (
        .clk(clk),
        .rst(rst),
        .send(send),
        .station_id(station_id),
        .BC(bc_o),
        .busy(busy_o),
        .done(done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic bc;
        logic busy;
        logic done;
    } smp_t;

    // lows[8] is the start cell, lows[7..0] the data cells in send order
    typedef struct packed {
        logic [7:0]      id;
        logic [8:0][3:0] lows;
    } vec_t;

    vec_t       tbl [5];
    smp_t       expq[$];
    logic [7:0] rxq[$];

    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    lowrun = 0;
    int    rx_cnt = 0;
    int    rx_bad = 0;
    logic  rx_act = 1'b0;
    logic [7:0] rx_sr = 8'h00;
    string tag = "reset";

    task automatic check_val(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    // Expected samples for one frame, optionally cut short after `limit`
    task automatic push_frame(input vec_t v, input int limit);
        smp_t s;
        int   n;
        n = 0;
        for (int c = 0; c < 9; c++) begin
            for (int k = 0; k < P; k++) begin
                s = '{bc: (k >= int'(v.lows[8-c])), busy: 1'b1, done: 1'b0};
                if (n < limit) expq.push_back(s);
                n++;
            end
        end
        for (int k = 0; k < P; k++) begin
            if (n < limit) expq.push_back('{bc: 1'b1, busy: 1'b1, done: 1'b0});
            n++;
        end
        if (n < limit) expq.push_back('{bc: 1'b1, busy: 1'b0, done: 1'b1});
    endtask

    // Pulse-width receiver: classify each completed low pulse
    task automatic rx_sample();
        if (!bc_o) begin
            lowrun++;
        end else if (lowrun != 0) begin
            if (lowrun == P / 2) begin
                rx_act = 1'b1;
                rx_cnt = 0;
                rx_sr  = 8'h00;
            end else if (rx_act && (lowrun == P / 4 || lowrun == 3 * P / 4)) begin
                rx_sr = {rx_sr[6:0], (lowrun == P / 4)};
                rx_cnt++;
                if (rx_cnt == 8) begin
                    rxq.push_back(rx_sr);
                    rx_act = 1'b0;
                end
            end else begin
                rx_bad++;
            end
            lowrun = 0;
        end
        if (done_o) done_cnt++;
    endtask

    task automatic step(input logic s, input logic [7:0] id, input logic r);
        smp_t e;
        smp_t a;
        send = s;
        station_id = id;
        rst = r;
        @(posedge clk);
        #1;
        cyc++;
        e = (expq.size() != 0) ? expq.pop_front()
                               : '{bc: 1'b1, busy: 1'b0, done: 1'b0};
        a = '{bc: bc_o, busy: busy_o, done: done_o};
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s cyc %0d: got bc/busy/done=%b%b%b want %b%b%b",
                      tag, cyc, a.bc, a.busy, a.done, e.bc, e.busy, e.done);
        rx_sample();
    endtask

    task automatic idle_steps(input int n);
        repeat (n) step(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic check_rx(input string name, input logic [7:0] id);
        if (rxq.size() == 0) check_val({name, "_rx_none"}, 1, 0);
        else check_val({name, "_rx_id"}, int'(rxq.pop_front()), int'(id));
    endtask

    int d0;

    initial begin
        tbl[0] = {8'hA5, {4'd8, 4'd4, 4'd12, 4'd4, 4'd12, 4'd12, 4'd4, 4'd12, 4'd4}};
        tbl[1] = {8'h00, {4'd8, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12}};
        tbl[2] = {8'hFF, {4'd8, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd4}};
        tbl[3] = {8'h81, {4'd8, 4'd4, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd12, 4'd4}};
        tbl[4] = {8'h12, {4'd8, 4'd12, 4'd12, 4'd12, 4'd4, 4'd12, 4'd12, 4'd4, 4'd12}};

        tag = "reset";
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle_steps(3);

        // Clean frames from the table
        for (int i = 0; i < 3; i++) begin
            tag = $sformatf("frame_%02h", tbl[i].id);
            d0 = done_cnt;
            push_frame(tbl[i], FRAME + 1);
            step(1'b1, tbl[i].id, 1'b0);
            idle_steps(FRAME);
            idle_steps(2);
            check_val({tag, "_done"}, done_cnt - d0, 1);
            check_rx(tag, tbl[i].id);
        end

        // Requests during a frame are dropped
        tag = "ignore_send";
        d0 = done_cnt;
        push_frame(tbl[0], FRAME + 1);
        step(1'b1, 8'hA5, 1'b0);
        for (int c = 1; c <= FRAME; c++) begin
            step((c == 5 || c == 40 || c == 100), 8'h3C, 1'b0);
        end
        idle_steps(3);
        check_val("ignore_send_done", done_cnt - d0, 1);
        check_rx(tag, 8'hA5);

        // Reset inside data cell 4 truncates the frame without done
        tag = "mid_reset";
        d0 = done_cnt;
        push_frame(tbl[0], 4 * P + 4);
        step(1'b1, 8'hA5, 1'b0);
        idle_steps(4 * P + 3);
        step(1'b0, 8'h00, 1'b1);
        idle_steps(3);
        check_val("mid_reset_no_done", done_cnt - d0, 0);
        check_val("mid_reset_no_rx", rxq.size(), 0);
        tag = "after_reset_12";
        push_frame(tbl[4], FRAME + 1);
        step(1'b1, 8'h12, 1'b0);
        idle_steps(FRAME + 2);
        check_val("after_reset_done", done_cnt - d0, 1);
        check_rx(tag, 8'h12);

        // send held high: frames separated by trailer plus one idle cycle
        tag = "send_held";
        d0 = done_cnt;
        for (int f = 0; f < 3; f++) push_frame(tbl[3], FRAME + 1);
        repeat (3 * (FRAME + 1)) step(1'b1, 8'h81, 1'b0);
        idle_steps(3);
        check_val("send_held_done", done_cnt - d0, 3);
        for (int f = 0; f < 3; f++) check_rx(tag, 8'h81);

        // Reset wins over a simultaneous send
        tag = "rst_and_send";
        d0 = done_cnt;
        step(1'b1, 8'h55, 1'b1);
        idle_steps(P);
        check_val("rst_and_send_idle", done_cnt - d0, 0);

        check_val("rx_bad_pulses", rx_bad, 0);
        check_val("scoreboard_drained", expq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
